// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one data-RAM port between the CPU load/store unit and the host
// debug/load port. The RAM has separate read and write channels and a
// synchronous read with 1-cycle latency.
//
// The CPU has fixed priority. A host request that has been refused MAX_WAIT
// consecutive cycles is granted by force, which stalls the CPU for that cycle.
//
// Parameters
//   AW        RAM address width
//   DW        RAM data width
//   MAX_WAIT  refused cycles before a forced host grant (1..15)
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   cpu_rd/cpu_wr                CPU load / store request
//   cpu_raddr/cpu_waddr          CPU read / write address
//   cpu_wdata                    CPU store data
//   cpu_rdata                    CPU load data (cycle after accepted load)
//   cpu_stall                    CPU request refused this cycle
//   host_req/host_we             host request, 1 = write / 0 = read
//   host_addr/host_wdata         host address / write data
//   host_ack                     host request consumed this cycle
//   host_rdata/host_rvalid       host read data / valid (cycle after ack)
//   ram_rd/ram_wr                RAM read / write strobes
//   ram_raddr/ram_waddr          RAM addresses
//   ram_wdata                    RAM write data
//   ram_rdata                    RAM read data (1-cycle latency)
// ----------------------------------------------------------------------------
module ram_port_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_raddr,
   input  logic [AW-1:0] cpu_waddr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          ram_rd,
   output logic          ram_wr,
   output logic [AW-1:0] ram_raddr,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   // Grant "states": purely combinational, recomputed every cycle.
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CPU_GNT  = 2'd1;
   localparam logic [1:0] ST_HOST_GNT = 2'd2;

   // Owner of the read issued in the previous cycle.
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_HOST = 2'd2;

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [3:0]    wait_cnt_reg;
   logic [3:0]    wait_cnt_next;
   logic [1:0]    rd_owner_reg;
   logic [1:0]    rd_owner_next;
   logic [DW-1:0] host_rdata_reg;

   logic          cpu_act;
   logic          force_host;
   logic [1:0]    gnt;

   // ------------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------------
   always_comb begin
      cpu_act    = cpu_rd | cpu_wr;
      force_host = host_req & (wait_cnt_reg == WAIT_LIMIT);
      if (force_host)
         gnt = ST_HOST_GNT;
      else if (cpu_act)
         gnt = ST_CPU_GNT;
      else if (host_req)
         gnt = ST_HOST_GNT;
      else
         gnt = ST_IDLE;
   end

   // ------------------------------------------------------------------------
   // RAM channel steering; the ungranted side drives nothing onto the port
   // ------------------------------------------------------------------------
   always_comb begin
      ram_rd    = 1'b0;
      ram_wr    = 1'b0;
      ram_raddr = '0;
      ram_waddr = '0;
      ram_wdata = '0;
      host_ack  = 1'b0;
      case (gnt)
         ST_CPU_GNT: begin
            // Load and store may go out together on the two channels.
            ram_rd    = cpu_rd;
            ram_wr    = cpu_wr;
            ram_raddr = cpu_raddr;
            ram_waddr = cpu_waddr;
            ram_wdata = cpu_wdata;
         end
         ST_HOST_GNT: begin
            host_ack  = 1'b1;
            ram_rd    = ~host_we;
            ram_wr    = host_we;
            ram_raddr = host_addr;
            ram_waddr = host_addr;
            ram_wdata = host_wdata;
         end
         default: begin
         end
      endcase
   end

   // The CPU only ever loses the port to a forced host grant.
   assign cpu_stall = cpu_act & force_host;

   // ------------------------------------------------------------------------
   // Next-state for the registered bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      // Counts refused cycles of the current host request; any ack or a
      // dropped request restarts the count.
      wait_cnt_next = 4'd0;
      if (host_req && (gnt != ST_HOST_GNT)) begin
         if (wait_cnt_reg == WAIT_LIMIT)
            wait_cnt_next = wait_cnt_reg;
         else
            wait_cnt_next = wait_cnt_reg + 4'd1;
      end

      rd_owner_next = OWN_NONE;
      if ((gnt == ST_CPU_GNT) && cpu_rd)
         rd_owner_next = OWN_CPU;
      else if ((gnt == ST_HOST_GNT) && !host_we)
         rd_owner_next = OWN_HOST;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_reg   <= 4'd0;
         rd_owner_reg   <= OWN_NONE;
         host_rdata_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         rd_owner_reg <= rd_owner_next;
         if (rd_owner_reg == OWN_HOST)
            host_rdata_reg <= ram_rdata;
      end
   end

   // ------------------------------------------------------------------------
   // Read return
   // ------------------------------------------------------------------------
   // The CPU sees the RAM output directly; it only consumes it after a load.
   assign cpu_rdata   = ram_rdata;
   assign host_rvalid = (rd_owner_reg == OWN_HOST);
   // RAM data arrives in the return cycle, so the host sees it straight
   // through while valid (one cycle after ack) and the captured copy after.
   assign host_rdata  = host_rvalid ? ram_rdata : host_rdata_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Directed scenarios followed by randomized CPU/host traffic against a RAM
// model. A reference model tracks the host's refused-cycle count, a shadow
// copy of the RAM contents and the expected read returns, and is compared
// with the DUT on every falling clock edge.
// ----------------------------------------------------------------------------
module tb_ram_port_arbiter;
   localparam int AW       = 8;
   localparam int DW       = 16;
   localparam int MAX_WAIT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [AW-1:0] cpu_raddr = '0, cpu_waddr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          host_req = 1'b0, host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_ack;
   logic [DW-1:0] host_rdata;
   logic          host_rvalid;
   logic          ram_rd, ram_wr;
   logic [AW-1:0] ram_raddr, ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int checks = 0;
   int errors = 0;
   int lit_id = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .ram_rd(ram_rd), .ram_wr(ram_wr),
      .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // ---------------- RAM model: synchronous read, read-before-write --------
   function automatic logic [DW-1:0] init_val(int i);
      return DW'(32'hA000 ^ (i * 37));
   endfunction

   logic [DW-1:0] ram_mem [0:255];
   logic [DW-1:0] ram_q = '0;
   initial for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
   always @(posedge clk) begin
      if (ram_rd) ram_q <= ram_mem[ram_raddr];
      if (ram_wr) ram_mem[ram_waddr] <= ram_wdata;
   end
   assign ram_rdata = ram_q;

   // ---------------- comparison helper ------------------------------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + checker -----------------------------
   logic [DW-1:0] shadow [0:255];
   initial for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
   int            refused = 0;
   bit            pend_host = 0, pend_cpu = 0;
   logic [DW-1:0] pend_hdata = '0, pend_cdata = '0, last_hdata = '0;
   bit            m_cpu_act, m_host_gets;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_rvalid", 32'(host_rvalid), 32'd0);
         chk("rst_rdata",  32'(host_rdata),  32'd0);
         chk("rst_ack",    32'(host_ack),    32'd0);
         chk("rst_stall",  32'(cpu_stall),   32'd0);
         chk("rst_strobes", 32'({ram_rd, ram_wr}), 32'd0);
         refused   = 0;
         pend_host = 0;
         pend_cpu  = 0;
         last_hdata = '0;
      end else begin
         // hand-computed expectations for the directed scenarios
         case (lit_id)
            1: begin
               chk("hw_ack", 32'(host_ack), 32'd1);
               chk("hw_wr", 32'(ram_wr), 32'd1);
               chk("hw_waddr", 32'(ram_waddr), 32'h10);
               chk("hw_wdata", 32'(ram_wdata), 32'hBEEF);
            end
            2: begin
               chk("hr_ack", 32'(host_ack), 32'd1);
               chk("hr_rd", 32'(ram_rd), 32'd1);
               chk("hr_wr", 32'(ram_wr), 32'd0);
               chk("hr_raddr", 32'(ram_raddr), 32'h10);
            end
            3: begin
               chk("hr_rvalid", 32'(host_rvalid), 32'd1);
               chk("hr_rdata", 32'(host_rdata), 32'hBEEF);
            end
            4: begin
               chk("hr_rvalid_end", 32'(host_rvalid), 32'd0);
               chk("hr_rdata_hold", 32'(host_rdata), 32'hBEEF);
            end
            5: begin
               chk("refused_ack", 32'(host_ack), 32'd0);
               chk("refused_stall", 32'(cpu_stall), 32'd0);
            end
            6: begin
               chk("forced_ack", 32'(host_ack), 32'd1);
               chk("forced_stall", 32'(cpu_stall), 32'd1);
               chk("forced_raddr", 32'(ram_raddr), 32'h10);
            end
            7: begin
               chk("forced_rvalid", 32'(host_rvalid), 32'd1);
               chk("forced_rdata", 32'(host_rdata), 32'hBEEF);
               chk("after_force_stall", 32'(cpu_stall), 32'd0);
            end
            8: begin
               chk("idle_slot_ack", 32'(host_ack), 32'd1);
               chk("idle_slot_stall", 32'(cpu_stall), 32'd0);
            end
            9: begin
               chk("dual_strobes", 32'({ram_rd, ram_wr}), 32'd3);
               chk("dual_raddr", 32'(ram_raddr), 32'h20);
               chk("dual_waddr", 32'(ram_waddr), 32'h21);
               chk("dual_wdata", 32'(ram_wdata), 32'h1234);
               chk("dual_ack", 32'(host_ack), 32'd0);
               chk("dual_stall", 32'(cpu_stall), 32'd0);
            end
            10: begin
               chk("drop_strobes", 32'({ram_rd, ram_wr}), 32'd0);
               chk("drop_ack", 32'(host_ack), 32'd0);
            end
            12: chk("post_rst_rvalid", 32'(host_rvalid), 32'd0);
            13: begin
               chk("forced2_ack", 32'(host_ack), 32'd1);
               chk("forced2_stall", 32'(cpu_stall), 32'd1);
            end
            default: ;
         endcase

         // model: host wins only when it has waited long enough or the CPU is idle
         m_cpu_act   = cpu_rd | cpu_wr;
         m_host_gets = host_req && (refused >= MAX_WAIT || !m_cpu_act);

         chk("ack", 32'(host_ack), 32'(m_host_gets));
         chk("stall", 32'(cpu_stall), 32'(m_cpu_act && m_host_gets));
         if (m_host_gets) begin
            chk("ram_rd_h", 32'(ram_rd), 32'(!host_we));
            chk("ram_wr_h", 32'(ram_wr), 32'(host_we));
            if (host_we) begin
               chk("waddr_h", 32'(ram_waddr), 32'(host_addr));
               chk("wdata_h", 32'(ram_wdata), 32'(host_wdata));
            end else begin
               chk("raddr_h", 32'(ram_raddr), 32'(host_addr));
            end
         end else begin
            chk("ram_rd_c", 32'(ram_rd), 32'(cpu_rd));
            chk("ram_wr_c", 32'(ram_wr), 32'(cpu_wr));
            if (cpu_rd) chk("raddr_c", 32'(ram_raddr), 32'(cpu_raddr));
            if (cpu_wr) begin
               chk("waddr_c", 32'(ram_waddr), 32'(cpu_waddr));
               chk("wdata_c", 32'(ram_wdata), 32'(cpu_wdata));
            end
         end

         chk("rvalid", 32'(host_rvalid), 32'(pend_host));
         chk("host_rdata", 32'(host_rdata), 32'(pend_host ? pend_hdata : last_hdata));
         if (pend_cpu) chk("cpu_rdata", 32'(cpu_rdata), 32'(pend_cdata));

         // advance the model by one cycle
         if (pend_host) last_hdata = pend_hdata;
         refused   = (host_req && !m_host_gets) ? refused + 1 : 0;
         pend_host = m_host_gets && !host_we;
         pend_cpu  = !m_host_gets && cpu_rd;
         if (pend_host) pend_hdata = shadow[host_addr];
         if (pend_cpu)  pend_cdata = shadow[cpu_raddr];
         if (m_host_gets && host_we)  shadow[host_addr] = host_wdata;
         if (!m_host_gets && cpu_wr)  shadow[cpu_waddr] = cpu_wdata;
      end
   end

   // ---------------- stimulus ----------------------------------------------
   task automatic drive(bit c_rd, bit c_wr, int c_ra, int c_wa, int c_wd,
                        bit h_req, bit h_we, int h_a, int h_wd, int lit);
      @(posedge clk);
      #1;
      cpu_rd     = c_rd;
      cpu_wr     = c_wr;
      cpu_raddr  = AW'(c_ra);
      cpu_waddr  = AW'(c_wa);
      cpu_wdata  = DW'(c_wd);
      host_req   = h_req;
      host_we    = h_we;
      host_addr  = AW'(h_a);
      host_wdata = DW'(h_wd);
      lit_id     = lit;
   endtask

   bit stalled, acked;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // host only: write then read back
      drive(0, 0, 0, 0, 0, 1, 1, 'h10, 'hBEEF, 1);
      drive(0, 0, 0, 0, 0, 1, 0, 'h10, 0, 2);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4);

      // continuous CPU loads, host read forced through on its 5th cycle
      for (int k = 0; k < MAX_WAIT; k++) drive(1, 0, 'h30 + k, 0, 0, 1, 0, 'h10, 0, 5);
      drive(1, 0, 'h34, 0, 0, 1, 0, 'h10, 0, 6);
      drive(1, 0, 'h34, 0, 0, 0, 0, 0, 0, 7);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // CPU idle cycle while host has waited 2 cycles
      drive(1, 0, 'h31, 0, 0, 1, 0, 'h11, 0, 0);
      drive(1, 0, 'h32, 0, 0, 1, 0, 'h11, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0, 'h11, 0, 8);
      // counter restarted: the next request waits the full MAX_WAIT again
      for (int k = 0; k < MAX_WAIT; k++) drive(1, 0, 'h33, 0, 0, 1, 1, 'h50, 'h5555, 5);
      drive(1, 0, 'h33, 0, 0, 1, 1, 'h50, 'h5555, 13);
      drive(1, 0, 'h33, 0, 0, 0, 0, 0, 0, 0);

      // simultaneous CPU load and store, host held off without stall
      drive(1, 1, 'h20, 'h21, 'h1234, 1, 1, 'h41, 'h7777, 9);
      drive(0, 0, 0, 0, 0, 1, 1, 'h41, 'h7777, 8);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // host drops its request after 3 refused cycles
      for (int k = 0; k < 3; k++) drive(1, 0, 'h22, 0, 0, 1, 0, 'h12, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 10);
      for (int k = 0; k < MAX_WAIT; k++) drive(1, 0, 'h23, 0, 0, 1, 0, 'h12, 0, 5);
      drive(1, 0, 'h23, 0, 0, 1, 0, 'h12, 0, 13);
      drive(1, 0, 'h23, 0, 0, 0, 0, 0, 0, 0);

      // reset asserted the cycle after a host read ack
      drive(0, 0, 0, 0, 0, 1, 0, 'h10, 0, 2);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      lit_id = 12;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // randomized traffic; CPU holds when stalled, host holds until ack
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         #1;
         stalled = cpu_stall;
         acked   = host_ack;
         @(posedge clk);
         #1;
         if (!stalled) begin
            cpu_rd    = ($urandom_range(0, 9) < 6);
            cpu_wr    = ($urandom_range(0, 9) < 3);
            cpu_raddr = AW'($urandom_range(0, 15));
            cpu_waddr = AW'($urandom_range(0, 15));
            cpu_wdata = DW'($urandom);
         end
         if (host_req && !acked) begin
            if ($urandom_range(0, 15) == 0) host_req = 1'b0;
         end else begin
            host_req   = $urandom_range(0, 1) == 1;
            host_we    = $urandom_range(0, 1) == 1;
            host_addr  = AW'($urandom_range(0, 15));
            host_wdata = DW'($urandom);
         end
      end

      @(posedge clk);
      #1;
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      host_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
